pong_game_ctrl: RTL
===================

// Module: pong_game_ctrl
// PURPOSE
//  Top-level match sequencer for the PingPong game. Issues reset_game to the paddle
//  movement block, gates paddle motion, and times the serve delay and the inter-point
//  pause in video frames. Counts both scores, decides the winner, and launches the ball.
//  Sits between the frame-timing/ball logic and the paddle movement datapath.
// PARAMETERS
//  WIN_SCORE     7   points needed to win the match (1..2**SCORE_W-1)
//  SCORE_W       4   width of each score counter
//  SERVE_FRAMES  60  frame_ticks spent in SERVE before launch (>=1)
//  POINT_FRAMES  90  frame_ticks of pause after a point (>=1)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        async active-low reset
//  start        in   1        1-cycle pulse, synchronous to clk; starts a new match
//  frame_tick   in   1        1-cycle pulse, once per video frame
//  miss_l       in   1        1-cycle pulse: ball passed the left (player 1) edge
//  miss_r       in   1        1-cycle pulse: ball passed the right (player 2) edge
//  reset_game   out  1        1-cycle pulse: paddles return to home position
//  paddle_en    out  1        1 = paddle movement block may update positions
//  ball_launch  out  1        1-cycle pulse: ball starts moving from centre
//  serve_dir    out  1        0 = ball travels toward player 1, 1 = toward player 2
//  score1       out  SCORE_W  player 1 score
//  score2       out  SCORE_W  player 2 score
//  winner       out  2        00 = none, 01 = player 1, 10 = player 2
//  state        out  3        current FSM state code (debug)
// BEHAVIOUR
//  - All outputs are registered. Reset (async, rst_n=0) sets state=IDLE and all
//    outputs to 0, and clears the frame counter. Reset mid-match abandons the match.
//  - States: IDLE=0, HOME=1, SERVE=2, PLAY=3, POINT=4, OVER=5.
//  - IDLE/OVER: paddle_en=0.
//    - start=1 -> HOME. Clear score1, score2 and winner. Set serve_dir=0.
//  - HOME: lasts exactly 1 cycle. reset_game=1 during this cycle only.
//    - Clear the frame counter, then -> SERVE. frame_tick is ignored in HOME.
//  - SERVE: paddle_en=1. The counter increments on each frame_tick.
//    - On the SERVE_FRAMES-th tick -> PLAY.
//    - ball_launch=1 in the first PLAY cycle only.
//  - PLAY: paddle_en=1.
//    - miss_r alone: score1+1, serve_dir=1.
//    - miss_l alone: score2+1, serve_dir=0.
//    - miss_l and miss_r in the same cycle: no score change, serve_dir kept, -> POINT.
//    - After a scoring miss: if the new score == WIN_SCORE -> OVER, with winner
//      updated in the same cycle as the score. Otherwise -> POINT and clear the counter.
//  - POINT: paddle_en=0. Count frame_ticks. On the POINT_FRAMES-th tick -> HOME.
//    - Scores are kept (the start-only clears apply only on start).
//  - Ignored events: miss_* outside PLAY; start outside IDLE/OVER.
//  - Scores never wrap; WIN_SCORE stops a match before overflow.
//  - The frame counter is $clog2(max(SERVE_FRAMES,POINT_FRAMES)+1) bits wide and
//    never exceeds its limit.
// TESTING (bench params: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2)
//  1. Reset, then start -> reset_game high 1 cycle, state 1->2, paddle_en=1.
//     After 2 ticks: ball_launch 1-cycle pulse, state=3.
//  2. miss_r in PLAY -> score1=1, serve_dir=1, state=4, paddle_en=0.
//     After 2 ticks: reset_game pulse, then SERVE.
//  3. miss_l and miss_r in the same PLAY cycle -> scores unchanged, serve_dir unchanged,
//     state=4.
//  4. Three miss_l events over three rallies -> score2=3, winner=2'b10, state=5.
//     Further misses are ignored. start -> scores=0, winner=0, reset_game pulse.
//  5. start during PLAY and miss_l during SERVE -> no state or score change.
//     frame_tick during HOME -> counter not advanced.
//  6. rst_n low mid-SERVE with the counter at 1 -> all outputs 0, state=0 immediately.
//     After release, start runs the full 2-tick serve delay again.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the PingPong game.
// Drives paddle home/enable, times the serve and the post-point pause in frames,
// keeps both scores, declares the winner and launches the ball.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               reset_game,
  output logic               paddle_en,
  output logic               ball_launch,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  // Frame counter only has to reach the longer of the two delays.
  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_home  = 3'd1,
    st_serve = 3'd2,
    st_play  = 3'd3,
    st_point = 3'd4,
    st_over  = 3'd5
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SCORE_W-1:0] score1_reg, score1_next;
  logic [SCORE_W-1:0] score2_reg, score2_next;
  logic [1:0]         winner_reg, winner_next;
  logic               dir_reg, dir_next;
  logic               reset_game_reg, reset_game_next;
  logic               paddle_en_reg, paddle_en_next;
  logic               ball_launch_reg, ball_launch_next;

  logic [SCORE_W-1:0] s1_inc, s2_inc;

  assign s1_inc = score1_reg + SCORE_W'(1);
  assign s2_inc = score2_reg + SCORE_W'(1);

  // State, counter, scores and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= st_idle;
      cnt_reg         <= '0;
      score1_reg      <= '0;
      score2_reg      <= '0;
      winner_reg      <= 2'b00;
      dir_reg         <= 1'b0;
      reset_game_reg  <= 1'b0;
      paddle_en_reg   <= 1'b0;
      ball_launch_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      score1_reg      <= score1_next;
      score2_reg      <= score2_next;
      winner_reg      <= winner_next;
      dir_reg         <= dir_next;
      reset_game_reg  <= reset_game_next;
      paddle_en_reg   <= paddle_en_next;
      ball_launch_reg <= ball_launch_next;
    end
  end

  // Next-state logic; outputs are derived from the upcoming state so they
  // line up with the state they describe once registered.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    score1_next = score1_reg;
    score2_next = score2_reg;
    winner_next = winner_reg;
    dir_next    = dir_reg;

    case (state_reg)
      st_idle, st_over: begin
        if (start) begin
          state_next  = st_home;
          score1_next = '0;
          score2_next = '0;
          winner_next = 2'b00;
          dir_next    = 1'b0;
        end
      end
      st_home: begin
        // frame_tick is deliberately ignored here: the serve delay starts fresh.
        cnt_next   = '0;
        state_next = st_serve;
      end
      st_serve: begin
        if (frame_tick) begin
          if (cnt_reg == CNT_W'(SERVE_FRAMES - 1)) begin
            cnt_next   = '0;
            state_next = st_play;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      st_play: begin
        if (miss_l && miss_r) begin
          // Simultaneous misses cancel out: replay the point without scoring.
          cnt_next   = '0;
          state_next = st_point;
        end else if (miss_r) begin
          score1_next = s1_inc;
          dir_next    = 1'b1;
          if (s1_inc == SCORE_W'(WIN_SCORE)) begin
            winner_next = 2'b01;
            state_next  = st_over;
          end else begin
            cnt_next   = '0;
            state_next = st_point;
          end
        end else if (miss_l) begin
          score2_next = s2_inc;
          dir_next    = 1'b0;
          if (s2_inc == SCORE_W'(WIN_SCORE)) begin
            winner_next = 2'b10;
            state_next  = st_over;
          end else begin
            cnt_next   = '0;
            state_next = st_point;
          end
        end
      end
      st_point: begin
        if (frame_tick) begin
          if (cnt_reg == CNT_W'(POINT_FRAMES - 1)) begin
            cnt_next   = '0;
            state_next = st_home;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = st_idle;
      end
    endcase

    reset_game_next  = (state_next == st_home);
    paddle_en_next   = (state_next == st_serve) || (state_next == st_play);
    ball_launch_next = (state_reg == st_serve) && (state_next == st_play);
  end

  assign reset_game  = reset_game_reg;
  assign paddle_en   = paddle_en_reg;
  assign ball_launch = ball_launch_reg;
  assign serve_dir   = dir_reg;
  assign score1      = score1_reg;
  assign score2      = score2_reg;
  assign winner      = winner_reg;
  assign state       = state_reg;

endmodule
